// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared constants for the seven-segment display path.
//   - DIGIT_W      : width of the glyph code carried on the digit-code interface
//   - GLYPH_*      : non-numeric glyph codes (codes 0..9 are the decimal digits)
//   - SEG_*        : active-low segment patterns, bit order {g,f,e,d,c,b,a}
// Imported by the scan driver, its decoder, the interface and the
// display-control block so all agree on code meanings.
package sevenseg_pkg;

  localparam int DIGIT_W = 5;
  localparam int NUM_POS = 4;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [6:0]         seg_t;

  // Glyph codes above the decimal digits
  localparam digit_t GLYPH_L     = 5'd10;
  localparam digit_t GLYPH_R     = 5'd11;
  localparam digit_t GLYPH_I     = 5'd12;
  localparam digit_t GLYPH_O     = 5'd13;
  localparam digit_t GLYPH_DASH  = 5'd14;
  localparam digit_t GLYPH_BLANK = 5'd15;  // 15 and everything above is dark

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_0     = 7'h40;
  localparam seg_t SEG_1     = 7'h79;
  localparam seg_t SEG_2     = 7'h24;
  localparam seg_t SEG_3     = 7'h30;
  localparam seg_t SEG_4     = 7'h19;
  localparam seg_t SEG_5     = 7'h12;
  localparam seg_t SEG_6     = 7'h02;
  localparam seg_t SEG_7     = 7'h78;
  localparam seg_t SEG_8     = 7'h00;
  localparam seg_t SEG_9     = 7'h10;
  localparam seg_t SEG_L     = 7'h47;
  localparam seg_t SEG_R     = 7'h2F;
  localparam seg_t SEG_I     = 7'h4F;
  localparam seg_t SEG_O     = 7'h23;
  localparam seg_t SEG_DASH  = 7'h3F;

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// sevenseg_scan_driver_if: digit-code interface between the display-control
// block (master) and the panel-side scan driver (slave).
//   enable      : control -> driver, 1 = display on
//   digit       : control -> driver, glyph code for the position on anode_count
//   dp_mask     : control -> driver, decimal-point request per position
//   anode_count : driver -> control, position currently being scanned
//   scan_tick   : driver -> control, one-cycle pulse when anode_count advances
interface sevenseg_scan_driver_if;
  import sevenseg_pkg::*;

  logic         enable;
  digit_t       digit;
  logic [3:0]   dp_mask;
  logic [1:0]   anode_count;
  logic         scan_tick;

  modport master (
    output enable, digit, dp_mask,
    input  anode_count, scan_tick
  );

  modport slave (
    input  enable, digit, dp_mask,
    output anode_count, scan_tick
  );

endinterface

// File: rtl/sevenseg_decoder.sv
// sevenseg_decoder: combinational glyph-code to segment decode.
//   code : 5-bit glyph code (0..9 digits, 10..14 letters/dash, 15..31 dark)
//   seg  : active-low segments {g,f,e,d,c,b,a}
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  digit_t code,
  output seg_t   seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (code < GLYPH_BLANK) begin
      case (code)
        5'd0:       seg = SEG_0;
        5'd1:       seg = SEG_1;
        5'd2:       seg = SEG_2;
        5'd3:       seg = SEG_3;
        5'd4:       seg = SEG_4;
        5'd5:       seg = SEG_5;
        5'd6:       seg = SEG_6;
        5'd7:       seg = SEG_7;
        5'd8:       seg = SEG_8;
        5'd9:       seg = SEG_9;
        GLYPH_L:    seg = SEG_L;
        GLYPH_R:    seg = SEG_R;
        GLYPH_I:    seg = SEG_I;
        GLYPH_O:    seg = SEG_O;
        GLYPH_DASH: seg = SEG_DASH;
        default:    seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed driver for a four-digit seven-segment
// panel. Owns the refresh counter and publishes the scanned position; the
// control block answers with a glyph code that is sampled a few cycles into
// each slot (blanking first hides ghosting while the code settles).
//   CLK, RESET : clock, synchronous active-high reset
//   dif        : digit-code interface (slave side)
//   an         : anode enables, active-low, one-hot when lit
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
// Parameters:
//   REFRESH_DIV : cycles per digit slot (>= 4)
//   SETTLE_CYC  : blanking cycles before the sample point (1..REFRESH_DIV-2)
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int SETTLE_CYC  = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  sevenseg_scan_driver_if.slave dif,
  output logic [3:0]            an,
  output seg_t                  seg,
  output logic                  dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SETTLE_CYC);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       anode_q;
  logic             tick_q;
  logic [3:0]       an_lit;
  seg_t             seg_dec;

  assign dif.anode_count = anode_q;
  assign dif.scan_tick   = tick_q;

  // Active-low one-hot anode for the current position
  for (genvar i = 0; i < NUM_POS; i++) begin : g_an
    assign an_lit[i] = ~(anode_q == 2'(i));
  end

  sevenseg_decoder u_dec (
    .code (dif.digit),
    .seg  (seg_dec)
  );

  // Slot end always blanks and advances; a low enable blanks on any other
  // edge; the sample edge latches the decoded glyph which then holds.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt     <= '0;
      anode_q <= 2'd0;
      tick_q  <= 1'b0;
      an      <= 4'hF;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      tick_q <= 1'b0;
      cnt    <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        cnt     <= '0;
        anode_q <= anode_q + 2'd1;
        tick_q  <= 1'b1;
        an      <= 4'hF;
        seg     <= SEG_BLANK;
        dp      <= 1'b1;
      end else if (!dif.enable) begin
        an  <= 4'hF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else if (cnt == CNT_SAMPLE) begin
        an  <= an_lit;
        seg <= seg_dec;
        dp  <= ~dif.dp_mask[anode_q];
      end
    end
  end

endmodule
